// File: rtl/reg_share_arbiter.sv
// -----------------------------------------------------------------------------
// reg_share_arbiter
//
// Purpose: four requesters share one WIDTH-bit register. Each cycle at most
// one requester is granted using round-robin priority; the winner's data is
// captured into the shared register at that same clock edge.
//
// Optional feature (compile-time macro ARB_LOCK_EN): grant locking. While the
// current owner keeps req and lock high it is regranted for up to MAX_LOCK
// consecutive captures, after which round-robin resumes. Without the macro the
// lock port is present but ignored.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-low reset
//   req      in   [3:0] write request per requester
//   d0..d3   in   [WIDTH-1:0] write data of requester 0..3
//   lock     in   [3:0] hold request per requester (ARB_LOCK_EN only)
//   gnt      out  [3:0] registered one-hot grant (zero when idle)
//   owner    out  [1:0] index of the last granted requester
//   q        out  [WIDTH-1:0] shared register contents
//   q_valid  out  high for one cycle after each capture
// -----------------------------------------------------------------------------
module reg_share_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [3:0]       lock,
  output logic [3:0]       gnt,
  output logic [1:0]       owner,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_LOCK  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       owner_q, owner_d;
  logic             valid_q, valid_d;

  // Data inputs gathered into an array so the winner index selects directly.
  logic [WIDTH-1:0] d_arr [4];
  assign d_arr[0] = d0;
  assign d_arr[1] = d1;
  assign d_arr[2] = d2;
  assign d_arr[3] = d3;

  // Round-robin pick: first set req bit scanning from ptr upward, modulo 4.
  logic [1:0] winner;
  logic       found;
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!found && req[ptr_q + 2'(k)]) begin
        winner = ptr_q + 2'(k);
        found  = 1'b1;
      end
    end
  end

`ifdef ARB_LOCK_EN
  localparam int CW = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
  localparam logic [CW-1:0] LOCK_LAST = CW'(MAX_LOCK - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          hold;

  // Regrant only while the register is actually owned (a capture happened
  // last cycle) and the owner still asks for it, bounded by the counter.
  assign hold = (state_q != S_IDLE) && req[owner_q] && lock[owner_q] &&
                (cnt_q < LOCK_LAST);
`endif

  always_comb begin
    state_d = S_IDLE;
    ptr_d   = ptr_q;
    data_d  = data_q;
    gnt_d   = '0;
    owner_d = owner_q;
    valid_d = 1'b0;
`ifdef ARB_LOCK_EN
    cnt_d   = '0;
    if (hold) begin
      // Locked regrant: pointer deliberately left where it was.
      state_d = S_LOCK;
      data_d  = d_arr[owner_q];
      gnt_d   = 4'b0001 << owner_q;
      valid_d = 1'b1;
      cnt_d   = cnt_q + CW'(1);
    end else
`endif
    if (found) begin
      state_d = S_GRANT;
      data_d  = d_arr[winner];
      gnt_d   = 4'b0001 << winner;
      owner_d = winner;
      valid_d = 1'b1;
      ptr_d   = winner + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
      gnt_q   <= '0;
      owner_q <= '0;
      valid_q <= 1'b0;
`ifdef ARB_LOCK_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      valid_q <= valid_d;
`ifdef ARB_LOCK_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

`ifndef ARB_LOCK_EN
  // Pure round-robin build: lock, the state register and MAX_LOCK have no
  // effect on the outputs; fold them into a sink so they are not flagged.
  logic unused_cfg;
  assign unused_cfg = ^{lock, state_q, 32'(MAX_LOCK)};
`endif

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign q       = data_q;
  assign q_valid = valid_q;

endmodule
